// File: rtl/hamming_enc_serial.sv
// Serial-in Hamming(IP_BIT+4, IP_BIT) encoder with optional single-bit error
// injection and a small output FIFO; codeword position 1 is the MSB of out_code.
module hamming_enc_serial #(
  parameter int IP_BIT     = 11,
  parameter int FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic              in_bit,
  input  logic [3:0]        inj_pos,
  output logic              in_ready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [IP_BIT+3:0] out_code,
  output logic [7:0]        word_cnt
);

  localparam int CW = IP_BIT + 4;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int NW = $clog2(FIFO_DEPTH + 1);
  localparam logic [3:0]    LAST_BIT = 4'(IP_BIT - 1);
  localparam logic [NW-1:0] FULL     = NW'(FIFO_DEPTH);

  // Data fills non-power-of-two positions in ascending order, MSB of data first;
  // each parity then covers the positions whose index has its bit set.
  function automatic logic [CW-1:0] encode(input logic [IP_BIT-1:0] data);
    logic [CW-1:0] code;
    int idx;
    code = '0;
    idx  = IP_BIT - 1;
    for (int p = 1; p <= CW; p++) begin
      if ((p & (p - 1)) != 0) begin
        code[CW-p] = data[idx];
        idx--;
      end
    end
    for (int k = 0; k < 4; k++) begin
      for (int p = 1; p <= CW; p++) begin
        if (((p & (p - 1)) != 0) && p[k]) code[CW-(1<<k)] ^= code[CW-p];
      end
    end
    return code;
  endfunction

  function automatic logic [CW-1:0] inject(input logic [CW-1:0] code, input logic [3:0] pos);
    logic [CW-1:0] res;
    res = code;
    for (int p = 1; p <= CW; p++) begin
      if (int'(pos) == p) res[CW-p] = ~res[CW-p];
    end
    return res;
  endfunction

  logic [IP_BIT-2:0] shift_p0;
  logic [3:0]        bit_cnt;
  logic [CW-1:0]     mem [FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr, rd_ptr, rd_next;
  logic [NW-1:0]     count, cnt_after_pop;
  logic              accept, push, pop;
  logic [CW-1:0]     code_p0;

  always_comb begin
    in_ready      = (count != FULL);
    out_valid     = (count != '0);
    accept        = in_valid && in_ready;
    push          = accept && (bit_cnt == LAST_BIT);
    pop           = out_valid && out_ready;
    rd_next       = pop ? rd_ptr + PW'(1) : rd_ptr;
    cnt_after_pop = count - NW'(pop);
    code_p0       = inject(encode({shift_p0, in_bit}), inj_pos);
  end

  // Stage p0: serial collection and FIFO storage (data only, no reset)
  always_ff @(posedge clk) begin
    if (accept) shift_p0 <= {shift_p0[IP_BIT-3:0], in_bit};
    if (push)   mem[wr_ptr] <= code_p0;
  end

  // out_code is a registered copy of the head so it holds after the FIFO drains.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt  <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      out_code <= '0;
      word_cnt <= '0;
    end else begin
      if (accept) bit_cnt <= push ? 4'd0 : bit_cnt + 4'd1;
      if (push) begin
        wr_ptr   <= wr_ptr + PW'(1);
        word_cnt <= word_cnt + 8'd1;
      end
      rd_ptr <= rd_next;
      count  <= count + NW'(push) - NW'(pop);
      if (cnt_after_pop == '0) begin
        if (push) out_code <= code_p0;
      end else begin
        out_code <= mem[rd_next];
      end
    end
  end

endmodule

// File: tb/tb_hamming_enc_serial.sv
// Directed bench for hamming_enc_serial: an 11-bit/depth-2 instance plus a
// 7-bit/depth-4 instance for the out-of-range injection boundary.
module tb_hamming_enc_serial;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_bit, in_ready, out_valid, out_ready;
  logic [3:0]  inj_pos;
  logic [14:0] out_code;
  logic [7:0]  word_cnt;

  logic        in_valid2, in_bit2, in_ready2, out_valid2, out_ready2;
  logic [3:0]  inj_pos2;
  logic [10:0] out_code2;
  logic [7:0]  word_cnt2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hamming_enc_serial #(.IP_BIT(11), .FIFO_DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_bit(in_bit), .inj_pos(inj_pos),
    .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
    .out_code(out_code), .word_cnt(word_cnt)
  );

  hamming_enc_serial #(.IP_BIT(7), .FIFO_DEPTH(4)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_bit(in_bit2), .inj_pos(inj_pos2),
    .in_ready(in_ready2), .out_valid(out_valid2), .out_ready(out_ready2),
    .out_code(out_code2), .word_cnt(word_cnt2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_accept(input logic which);
    int t = 0;
    while (!(which ? in_ready2 : in_ready) && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    if (!(which ? in_ready2 : in_ready)) begin
      checks++;
      errors++;
      $error("FAIL in_ready_timeout: observed 0 expected 1 within 200 cycles");
    end else begin
      @(posedge clk); #1;
    end
  endtask

  // Sends the top nbits of an 11-bit word, MSB first; inj applies to data[0].
  task automatic send_word(input logic [10:0] d, input logic [3:0] inj, input int nbits);
    for (int i = 10; i > 10 - nbits; i--) begin
      in_valid = 1'b1;
      in_bit   = d[i];
      inj_pos  = (i == 0) ? inj : 4'd0;
      wait_accept(1'b0);
    end
    in_valid = 1'b0;
    inj_pos  = 4'd0;
  endtask

  task automatic send_word2(input logic [6:0] d, input logic [3:0] inj);
    for (int i = 6; i >= 0; i--) begin
      in_valid2 = 1'b1;
      in_bit2   = d[i];
      inj_pos2  = (i == 0) ? inj : 4'd0;
      wait_accept(1'b1);
    end
    in_valid2 = 1'b0;
    inj_pos2  = 4'd0;
  endtask

  task automatic head_pop(input string tag, input logic [14:0] exp);
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_code"}, 32'(out_code), 32'(exp));
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic head_pop2(input string tag, input logic [10:0] exp);
    check({tag, "_valid"}, 32'(out_valid2), 32'd1);
    check({tag, "_code"}, 32'(out_code2), 32'(exp));
    out_ready2 = 1'b1;
    @(posedge clk); #1;
    out_ready2 = 1'b0;
  endtask

  function automatic int syndrome(input logic [14:0] c);
    int s = 0;
    for (int p = 1; p <= 15; p++) if (c[15-p]) s ^= p;
    return s;
  endfunction

  function automatic logic [10:0] extract(input logic [14:0] c);
    int dpos [11];
    logic [10:0] r;
    dpos = '{3, 5, 6, 7, 9, 10, 11, 12, 13, 14, 15};
    for (int j = 0; j < 11; j++) r[10-j] = c[15-dpos[j]];
    return r;
  endfunction

  initial begin
    int          exp_cnt;
    int          syn;
    logic [10:0] d;
    logic [3:0]  inj;
    logic [14:0] fixed;

    rst_n = 1'b0; in_valid = 1'b0; in_bit = 1'b0; inj_pos = 4'd0; out_ready = 1'b0;
    in_valid2 = 1'b0; in_bit2 = 1'b0; inj_pos2 = 4'd0; out_ready2 = 1'b0;
    #12;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_code", 32'(out_code), 32'd0);
    check("rst_word_cnt", 32'(word_cnt), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // First word and one-cycle latency
    send_word(11'h001, 4'd0, 11);
    check("w001_valid", 32'(out_valid), 32'd1);
    check("w001_code", 32'(out_code), 32'h6881);
    check("w001_cnt", 32'(word_cnt), 32'd1);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("drain_valid", 32'(out_valid), 32'd0);
    check("drain_hold", 32'(out_code), 32'h6881);

    // Back-to-back words with downstream always ready
    out_ready = 1'b1;
    send_word(11'h400, 4'd0, 11);
    check("w400_code", 32'(out_code), 32'h7000);
    check("w400_valid", 32'(out_valid), 32'd1);
    send_word(11'h7FF, 4'd0, 11);
    check("w7ff_code", 32'(out_code), 32'h7FFF);
    check("w7ff_valid", 32'(out_valid), 32'd1);
    @(posedge clk); #1;
    check("w7ff_once", 32'(out_valid), 32'd0);
    check("cnt3", 32'(word_cnt), 32'd3);
    out_ready = 1'b0;

    // Error injection
    send_word(11'h000, 4'd5, 11);
    head_pop("inj5", 15'h0400);
    send_word(11'h000, 4'd15, 11);
    head_pop("inj15", 15'h0001);
    send_word(11'h000, 4'd0, 11);
    head_pop("inj0", 15'h0000);

    // Backpressure: third word stalls until the FIFO drains
    send_word(11'h001, 4'd0, 11);
    check("bp_ready_after1", 32'(in_ready), 32'd1);
    send_word(11'h400, 4'd0, 11);
    check("bp_ready_full", 32'(in_ready), 32'd0);
    fork
      send_word(11'h7FF, 4'd0, 11);
      begin
        repeat (3) @(posedge clk);
        #1;
        check("bp_stalled_cnt", 32'(word_cnt), 32'd8);
        check("bp_still_full", 32'(in_ready), 32'd0);
        check("bp_head_a", 32'(out_code), 32'h6881);
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_head_b", 32'(out_code), 32'h7000);
        check("bp_ready_up", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("bp_empty", 32'(out_valid), 32'd0);
      end
    join
    head_pop("bp_head_c", 15'h7FFF);
    check("bp_cnt", 32'(word_cnt), 32'd9);

    // Async reset with a queued word and a partial word
    send_word(11'h001, 4'd0, 11);
    send_word(11'h7FF, 4'd0, 6);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_cnt", 32'(word_cnt), 32'd0);
    check("mid_rst_code", 32'(out_code), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    send_word(11'h001, 4'd0, 11);
    check("post_rst_cnt", 32'(word_cnt), 32'd1);
    head_pop("post_rst", 15'h6881);
    exp_cnt = 1;

    // Random words decoded by a reference syndrome decoder
    out_ready = 1'b1;
    for (int n = 0; n < 1000; n++) begin
      d   = 11'($urandom);
      inj = 4'($urandom_range(0, 15));
      send_word(d, inj, 11);
      exp_cnt++;
      syn = syndrome(out_code);
      fixed = out_code;
      if (syn != 0) fixed[15-syn] = ~fixed[15-syn];
      check("rnd_valid", 32'(out_valid), 32'd1);
      check("rnd_syndrome", 32'(syn), 32'(inj));
      check("rnd_data", 32'(extract(fixed)), 32'(d));
    end
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("rnd_cnt_wrap", 32'(word_cnt), 32'(exp_cnt % 256));

    // 7-bit instance: out-of-range injection and depth-4 fill
    send_word2(7'h01, 4'd0);
    send_word2(7'h00, 4'd15);
    send_word2(7'h00, 4'd11);
    send_word2(7'h00, 4'd12);
    check("d4_full", 32'(in_ready2), 32'd0);
    check("d4_cnt", 32'(word_cnt2), 32'd4);
    head_pop2("d4_w01", 11'h609);
    head_pop2("d4_inj15", 11'h000);
    head_pop2("d4_inj11", 11'h001);
    head_pop2("d4_inj12", 11'h000);
    check("d4_empty", 32'(out_valid2), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hamming_enc_serial.md
Name: hamming_enc_serial

Overview:
- Upstream companion to the team's Hamming(IP_BIT+4, IP_BIT) single-error-correcting decoder IP.
- Collects IP_BIT data bits serially, MSB first, and computes the four parity bits.
- Optionally flips one codeword bit for error-injection testing, then buffers codewords in a small FIFO.
- Presents codewords downstream over a valid/ready handshake, in exactly the bit layout the decoder consumes.

Parameters:
- IP_BIT, 11, data bits per word; legal range 5..11; codeword width is IP_BIT+4.
- FIFO_DEPTH, 2, output FIFO entries; legal values 2 or 4.

Ports:
- clk  in  1  single clock, all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  in_bit is valid this cycle.
- in_bit  in  1  serial data bit, MSB (data[IP_BIT-1]) first.
- inj_pos  in  4  error-injection position, sampled only with the last bit of a word; 0 means no injection.
- in_ready  out  1  block accepts in_bit this cycle.
- out_valid  out  1  out_code holds a codeword.
- out_ready  in  1  downstream accepts out_code this cycle.
- out_code  out  IP_BIT+4  codeword, FIFO head.
- word_cnt  out  8  count of codewords pushed into the FIFO, wraps 255->0.

Behaviour:
- Reset (async assert, sync-release safe):
  - out_valid=0, out_code=0, word_cnt=0, in_ready=1.
  - FIFO empty; bit counter 0; any partial word discarded.
- Codeword position map:
  - Positions run 1..IP_BIT+4; position p lives at out_code[IP_BIT+4-p], so position 1 is the MSB.
  - Parity bits sit at positions 1, 2, 4, 8.
  - Data placement: data[IP_BIT-1] -> pos 3; data[IP_BIT-2..IP_BIT-4] -> pos 5,6,7; data[IP_BIT-5..0] -> pos 9..IP_BIT+4, in descending data index.
- Parity rule:
  - Parity at pos 2^k = XOR of all data bits whose position has bit k set.
  - Result: the XOR of the position indices of all set bits (the syndrome) is 0.
- Input handshake:
  - A bit is accepted when in_valid && in_ready.
  - in_ready = registered FIFO count != FIFO_DEPTH. It may drop mid-word; the partial word is held, not lost.
  - A 4-bit counter tracks bits accepted. On the IP_BIT-th accepted bit, the counter returns to 0.
  - In that same cycle the combinational encoder (shift register plus the incoming bit) produces the codeword and it is pushed into the FIFO.
- Error injection:
  - If inj_pos is in 1..IP_BIT+4 on the last-bit cycle, bit out_code[IP_BIT+4-inj_pos] of the pushed word is inverted.
  - inj_pos=0 or inj_pos>IP_BIT+4: no change.
  - inj_pos is ignored on all other cycles.
- Latency: last bit accepted at cycle N -> out_valid=1 with that codeword at cycle N+1 when the FIFO was empty.
- Output handshake:
  - Pop when out_valid && out_ready.
  - out_code shows the next entry the cycle after a pop, or holds its value (not cleared) when the FIFO becomes empty.
  - out_valid = FIFO non-empty.
  - out_code is stable while out_valid=1 and out_ready=0.
- Simultaneous push and pop:
  - Count unchanged; order is preserved (FIFO, never overwrite).
  - Push is impossible when full because in_ready=0; pop when full is allowed and raises in_ready the next cycle.
- word_cnt increments on every push.
- Reset mid-word or mid-drain: everything returns to reset values immediately.

Test Plan:
- IP_BIT=11, serial data 11'h001, inj_pos=0 -> one cycle after the last bit, out_valid=1, out_code=15'h6881, word_cnt=1.
- Data 11'h400 then 11'h7FF back-to-back, out_ready=1 -> out_code 15'h7000 then 15'h7FFF, in order, each held for one cycle.
- Data 11'h000 with inj_pos=5 -> out_code=15'h0400; data 11'h000 with inj_pos=0 or inj_pos=15'd... (i.e. 4'hF with IP_BIT=7) handled per range rule. Feeding out_code to the decoder yields 11'h000.
- out_ready=0, three words streamed (FIFO_DEPTH=2):
  - in_ready falls after the second push; the third word's bits stall.
  - Raising out_ready drains 2 words, then the third arrives; none lost or reordered.
- Assert rst_n=0 after 6 bits of a word -> out_valid=0, word_cnt=0. A fresh 11-bit word 11'h001 afterwards yields 15'h6881, with no leftover bits.
- Random 1000 words with random inj_pos through the encoder and the decoder -> decoded data equals sent data for every word.
